// File: rtl/irq_dispatch_1_16.sv
// Sixteen-channel interrupt dispatcher: latches request bits into a pending
// register, serves them one at a time in round-robin order, and raises a
// timeout error when a channel fails to acknowledge in time.
module irq_dispatch_1_16 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_rec_in,
    input  logic        data_rec_valid,
    output logic        data_rec_ready,
    input  logic [15:0] ack_in,
    output logic [15:0] req_out,
    output logic [15:0] pending_out,
    output logic        busy,
    output logic        timeout_err,
    output logic [3:0]  err_chan
);

    typedef enum logic [1:0] {StIdle, StScan, StReq, StWaitLow} state_e;

    // Last counter value before the acknowledge window expires.
    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] req_q, req_d;
    logic [3:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  chan_q, chan_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  err_chan_q, err_chan_d;
    logic        timeout_err_q, timeout_err_d;

    logic [15:0] load_mask;
    logic [15:0] clear_mask;
    logic [3:0]  pick;
    logic [3:0]  pick_idx;
    logic        pick_found;
    logic        ack_cur;

    // Upper request bits carry no channels.
    logic unused_upper;
    assign unused_upper = ^data_rec_in[31:16];

    assign ack_cur = ack_in[chan_q];

    // Round-robin pick: lowest pending index at or above rr_ptr, wrapping 15 -> 0.
    always_comb begin
        pick       = rr_ptr_q;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pick_idx = rr_ptr_q + 4'(i);
            if (!pick_found && pending_q[pick_idx]) begin
                pick       = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    // Next-state, request, counter and pending-register logic.
    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        err_chan_d    = err_chan_q;
        timeout_err_d = 1'b0;
        clear_mask    = '0;
        load_mask     = data_rec_valid ? data_rec_in[15:0] : 16'h0000;

        case (state_q)
            StIdle: begin
                if (pending_q != 16'h0000) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (pick_found) begin
                    chan_d  = pick;
                    req_d   = 16'h0001 << pick;
                    cnt_d   = '0;
                    state_d = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 16'd1;
                // Acknowledge has priority over a coincident timeout.
                if (ack_cur) begin
                    clear_mask = 16'h0001 << chan_q;
                    req_d      = '0;
                    rr_ptr_d   = chan_q + 4'd1;
                    state_d    = StWaitLow;
                end else if (cnt_q == CntLast) begin
                    timeout_err_d = 1'b1;
                    err_chan_d    = chan_q;
                    clear_mask    = 16'h0001 << chan_q;
                    req_d         = '0;
                    rr_ptr_d      = chan_q + 4'd1;
                    state_d       = StIdle;
                end
            end
            StWaitLow: begin
                if (!ack_cur) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A load in the same cycle as a clear wins.
        pending_d = (pending_q & ~clear_mask) | load_mask;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            req_q         <= '0;
            rr_ptr_q      <= '0;
            chan_q        <= '0;
            cnt_q         <= '0;
            err_chan_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            req_q         <= req_d;
            rr_ptr_q      <= rr_ptr_d;
            chan_q        <= chan_d;
            cnt_q         <= cnt_d;
            err_chan_q    <= err_chan_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign data_rec_ready = rst;
    assign req_out        = req_q;
    assign pending_out    = pending_q;
    assign busy           = (state_q != StIdle);
    assign timeout_err    = timeout_err_q;
    assign err_chan       = err_chan_q;

endmodule

// File: tb/tb_irq_dispatch_1_16.sv
// Self-checking bench for irq_dispatch_1_16 built with a short timeout window.
module tb_irq_dispatch_1_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_rec_in;
    logic        data_rec_valid;
    logic        data_rec_ready;
    logic [15:0] ack_in;
    logic [15:0] req_out;
    logic [15:0] pending_out;
    logic        busy;
    logic        timeout_err;
    logic [3:0]  err_chan;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    irq_dispatch_1_16 #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_rec_in    (data_rec_in),
        .data_rec_valid (data_rec_valid),
        .data_rec_ready (data_rec_ready),
        .ack_in         (ack_in),
        .req_out        (req_out),
        .pending_out    (pending_out),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .err_chan       (err_chan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] w);
        data_rec_in    = w;
        data_rec_valid = 1'b1;
        tick();
        data_rec_valid = 1'b0;
        data_rec_in    = '0;
    endtask

    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (req_out == 16'h0000 && n < 20) begin
            tick();
            n++;
        end
        seen = (req_out != 16'h0000);
    endtask

    // Serve the next expected request with a prompt two-cycle acknowledge.
    task automatic serve(input string tag);
        bit seen;
        int exp;
        logic [15:0] want;
        wait_req(seen);
        exp  = exp_q.pop_front();
        want = 16'h0001 << exp;
        vectors++;
        if (!seen || req_out !== want) begin
            miscompares++;
            $display("FAIL %s_req: got %h want %h", tag, req_out, want);
        end
        tick();
        ack_in = want;
        tick();
        vectors++;
        if (req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s_ack_drop: got %h want 0000", tag, req_out);
        end
        tick();
        ack_in = '0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_fall: got %b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        data_rec_in    = 32'h0000_FFFF;
        data_rec_valid = 1'b1;
        ack_in         = '0;
        tick();
        tick();
        vectors++;
        if (req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_req: got %h want 0000", req_out);
        end
        vectors++;
        if (pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_pending: got %h want 0000", pending_out);
        end
        vectors++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || err_chan !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b terr=%b echan=%h want 0 0 0",
                     busy, timeout_err, err_chan);
        end
        vectors++;
        if (data_rec_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", data_rec_ready);
        end
        data_rec_valid = 1'b0;
        data_rec_in    = '0;
        rst            = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        write_word(32'h0000_8003);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(15);
        serve("rr_a0");
        serve("rr_a1");
        serve("rr_a15");
        // Serve channel 1 alone to leave rr_ptr at 2.
        write_word(32'h0000_0002);
        exp_q.push_back(1);
        serve("rr_set");
        write_word(32'h0000_8003);
        exp_q.push_back(15);
        exp_q.push_back(0);
        exp_q.push_back(1);
        serve("rr_b15");
        serve("rr_b0");
        serve("rr_b1");
        vectors++;
        if (pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL rr_pending_empty: got %h want 0000", pending_out);
        end
    endtask

    task automatic test_single();
        vectors++;
        if (data_rec_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 1", data_rec_ready);
        end
        write_word(32'h0000_0004);
        exp_q.push_back(2);
        vectors++;
        if (pending_out !== 16'h0004 || req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL single_edge_n: got pend=%h req=%h want 0004 0000",
                     pending_out, req_out);
        end
        tick();
        vectors++;
        if (req_out !== 16'h0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_edge_n1: got req=%h busy=%b want 0000 1", req_out, busy);
        end
        tick();
        vectors++;
        if (req_out !== 16'h0004) begin
            miscompares++;
            $display("FAIL single_edge_n2: got %h want 0004", req_out);
        end
        serve("single");
        vectors++;
        if (pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL single_pending: got %h want 0000", pending_out);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int exp;
        int high;
        int pulses;
        int n;
        write_word(32'h0000_0020);
        exp_q.push_back(5);
        wait_req(seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || req_out !== (16'h0001 << exp)) begin
            miscompares++;
            $display("FAIL to_req: got %h want %h", req_out, 16'h0001 << exp);
        end
        high   = seen ? 1 : 0;
        pulses = 0;
        n      = 0;
        do begin
            tick();
            if (timeout_err) pulses++;
            if (req_out[5]) high++;
            n++;
        end while (req_out[5] && n < 20);
        repeat (3) begin
            tick();
            if (timeout_err) pulses++;
        end
        vectors++;
        if (high != 4) begin
            miscompares++;
            $display("FAIL to_high_cycles: got %0d want 4", high);
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL to_pulses: got %0d want 1", pulses);
        end
        vectors++;
        if (err_chan !== 4'd5) begin
            miscompares++;
            $display("FAIL to_err_chan: got %0d want 5", err_chan);
        end
        vectors++;
        if (pending_out !== 16'h0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL to_idle: got pend=%h busy=%b want 0000 0", pending_out, busy);
        end
    endtask

    task automatic test_tie();
        bit seen;
        int exp;
        write_word(32'h0000_0040);
        exp_q.push_back(6);
        wait_req(seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || req_out !== (16'h0001 << exp)) begin
            miscompares++;
            $display("FAIL tie_req: got %h want %h", req_out, 16'h0001 << exp);
        end
        tick();
        tick();
        tick();
        ack_in = 16'h0040;
        tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL tie_wait_low: got terr=%b busy=%b req=%h want 0 1 0000",
                     timeout_err, busy, req_out);
        end
        tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_hold: got terr=%b busy=%b want 0 1", timeout_err, busy);
        end
        ack_in = '0;
        tick();
        vectors++;
        if (busy !== 1'b0 || pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL tie_release: got busy=%b pend=%h want 0 0000", busy, pending_out);
        end
    endtask

    task automatic test_collision();
        bit seen;
        int exp;
        write_word(32'h0000_0001);
        exp_q.push_back(0);
        wait_req(seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || req_out !== (16'h0001 << exp)) begin
            miscompares++;
            $display("FAIL col_req: got %h want %h", req_out, 16'h0001 << exp);
        end
        tick();
        ack_in         = 16'h0001;
        data_rec_in    = 32'h0000_0001;
        data_rec_valid = 1'b1;
        exp_q.push_back(0);
        tick();
        data_rec_valid = 1'b0;
        data_rec_in    = '0;
        vectors++;
        if (pending_out !== 16'h0001 || req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL col_load_wins: got pend=%h req=%h want 0001 0000",
                     pending_out, req_out);
        end
        tick();
        ack_in = '0;
        tick();
        serve("col_again");
        vectors++;
        if (pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL col_pending: got %h want 0000", pending_out);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int exp;
        write_word(32'h0000_0300);
        exp_q.push_back(8);
        wait_req(seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || req_out !== (16'h0001 << exp) || pending_out !== 16'h0300) begin
            miscompares++;
            $display("FAIL rmid_setup: got req=%h pend=%h want %h 0300",
                     req_out, pending_out, 16'h0001 << exp);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (req_out !== 16'h0000 || pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL rmid_clear: got req=%h pend=%h want 0000 0000", req_out, pending_out);
        end
        vectors++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_status: got busy=%b terr=%b want 0 0", busy, timeout_err);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_after: got terr=%b busy=%b want 0 0", timeout_err, busy);
        end
        write_word(32'hFFFF_0000);
        vectors++;
        if (pending_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL upper_ignored: got %h want 0000", pending_out);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || req_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL upper_idle: got busy=%b req=%h want 0 0000", busy, req_out);
        end
    endtask

    initial begin
        rst            = 1'b0;
        data_rec_in    = '0;
        data_rec_valid = 1'b0;
        ack_in         = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_tie();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_dispatch_1_16.md
IRQ_DISPATCH_1_16 -- requirements
Module: irq_dispatch_1_16

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of cycles a request waits for its acknowledge; the legal range is 2..65535.
REQ-002 clk  input  1  clock; every register updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 data_rec_in  input  32  request word; bits [15:0] carry one request bit per channel; bits [31:16] are ignored.
REQ-005 data_rec_valid  input  1  qualifies data_rec_in.
REQ-006 data_rec_ready  output  1  always 1 outside reset, so any word is accepted in any state.
REQ-007 ack_in  input  16  per-channel acknowledge, level-sensitive.
REQ-008 req_out  output  16  per-channel request, registered, one-hot or all zero.
REQ-009 pending_out  output  16  current pending-request register.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 timeout_err  output  1  one-cycle pulse raised on an acknowledge timeout.
REQ-012 err_chan  output  4  index of the channel that last timed out; holds its value until the next timeout.

Function
REQ-013 Pending update rule: pending_next = (pending & ~clear_mask) | load_mask.
- load_mask = data_rec_in[15:0] when data_rec_valid=1, otherwise 0.
- clear_mask is a one-hot mask for the channel completed or timed out in that cycle.
- If the same bit is loaded and cleared in one cycle, the load wins.
REQ-014 The FSM SHALL have exactly four states: IDLE, SCAN, REQ and WAIT_LOW.
REQ-015 IDLE -> SCAN when pending != 0; otherwise the FSM stays in IDLE.
REQ-016 SCAN SHALL perform the round-robin selection and then move to REQ.
- It selects the lowest pending index at or above rr_ptr; the search wraps from 15 to 0.
- The selected index is latched into chan.
REQ-017 In REQ:
- req_out[chan]=1 and every other req_out bit is 0.
- A 16-bit counter clears on REQ entry and increments once per cycle in REQ.
REQ-018 REQ, acknowledge path: when ack_in[chan]=1,
- clear pending[chan] and drop req_out on the next edge;
- set rr_ptr = (chan+1) mod 16;
- move to WAIT_LOW.
REQ-019 REQ, timeout path: when the counter equals TIMEOUT_CYCLES-1 and ack_in[chan]=0,
- pulse timeout_err for one cycle and load err_chan=chan;
- clear pending[chan] and set rr_ptr = (chan+1) mod 16;
- move to IDLE.
- As a result, req_out stays high for exactly TIMEOUT_CYCLES cycles.
REQ-020 If ack_in[chan] rises in the same cycle the counter reaches TIMEOUT_CYCLES-1, the acknowledge path wins and no timeout is flagged.
REQ-021 WAIT_LOW -> IDLE when ack_in[chan]=0; there is no timeout in WAIT_LOW.
REQ-022 ack_in bits other than ack_in[chan] SHALL be ignored in every state.
REQ-023 Latency: with the FSM idle and valid sampled at edge N, req_out is high after edge N+2.
- Back-to-back service costs 3 cycles minimum between successive requests (REQ exit -> WAIT_LOW -> IDLE -> SCAN -> REQ), given an immediate ack release.
REQ-024 pending_out SHALL equal the pending register with no added delay; busy SHALL be decoded from the state register.

Reset
REQ-025 When rst=0 at a rising edge, the following SHALL hold after that edge:
- state = IDLE;
- pending, req_out, rr_ptr, chan, counter, err_chan and timeout_err are all 0;
- busy = 0 and data_rec_ready = 0.
REQ-026 Reset during REQ or WAIT_LOW SHALL drop req_out on that edge and discard all pending requests; no timeout_err is generated.
REQ-027 While rst=0, data_rec_valid is ignored.

Verification
REQ-028 Single request, prompt acknowledge:
- Stimulus: write 0x0000_0004; hold ack_in[2]=1 for 2 cycles from 1 cycle after req_out[2] rises.
- Required response: req_out=0x0004 from edge N+2; pending_out returns to 0; busy falls one cycle after ack_in[2] falls.
REQ-029 Round-robin order with wrap:
- Stimulus: write 0x0000_8003 with rr_ptr=0 and acknowledge each request promptly; then, with rr_ptr=2, write 0x0000_0003 together with 0x8000.
- Required response: the first write is served in the order 0, 1, 15; the second is served in the order 15, 0, 1.
REQ-030 Timeout with TIMEOUT_CYCLES=4:
- Stimulus: write 0x0000_0020 and never acknowledge.
- Required response: req_out[5] is high for exactly 4 cycles; timeout_err pulses once; err_chan=5; pending_out=0; the FSM returns to IDLE.
REQ-031 Acknowledge versus timeout tie:
- Stimulus: raise ack_in in the final counter cycle.
- Required response: timeout_err stays 0 and the FSM moves to WAIT_LOW.
REQ-032 Load and clear collision:
- Stimulus: write 0x0000_0001 in the same cycle ack_in[0] completes channel 0.
- Required response: pending_out[0] stays 1 and channel 0 is served again.
REQ-033 Reset mid-operation:
- Stimulus: assert rst=0 while req_out=0x0100 and pending_out=0x0300.
- Required response: after the edge, req_out=0, pending_out=0, busy=0 and timeout_err=0.
- Also required: upper bits are ignored, so a write of 0xFFFF_0000 leaves pending_out=0.
